// File: rtl/rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rx_pkg
// Description : Shared QPSK constants and saturating magnitude helper.
// Revision    : 1.0
// ============================================================================
package rx_pkg;

    localparam int SAMPLE_W = 12;

    // Nominal +1.0 / -1.0 amplitudes used by the TX mapper
    localparam logic [SAMPLE_W-1:0] QPSK_POS = 12'h5A7;
    localparam logic [SAMPLE_W-1:0] QPSK_NEG = 12'hA59;

    // |x| with the most negative code clipped to the largest positive code
    function automatic logic [SAMPLE_W-1:0] sat_abs(input logic signed [SAMPLE_W-1:0] x);
        logic [SAMPLE_W-1:0] r;
        if (x == {1'b1, {(SAMPLE_W-1){1'b0}}}) begin
            r = {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else if (x[SAMPLE_W-1]) begin
            r = ~x + 1'b1;
        end else begin
            r = x;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/qpsk_slicer.sv
`default_nettype none
// ============================================================================
// Module      : qpsk_slicer
// Description : Hard sign decision on one {I, Q} sample plus weak-magnitude flag.
// Revision    : 1.0
// ============================================================================
module qpsk_slicer #(
    parameter int                  SAMPLE_W = 12,
    parameter logic [SAMPLE_W-1:0] WEAK_THR = 12'd724
) (
    input  logic [2*SAMPLE_W-1:0] iq_i,
    output logic                  bit_i_o,
    output logic                  bit_q_o,
    output logic                  weak_o
);
    import rx_pkg::*;

    logic signed [SAMPLE_W-1:0] w_i;
    logic signed [SAMPLE_W-1:0] w_q;

    assign w_i = iq_i[2*SAMPLE_W-1:SAMPLE_W];
    assign w_q = iq_i[SAMPLE_W-1:0];

    // Non-negative (including zero) decides 1
    assign bit_i_o = ~w_i[SAMPLE_W-1];
    assign bit_q_o = ~w_q[SAMPLE_W-1];
    assign weak_o  = (sat_abs(w_i) < WEAK_THR) | (sat_abs(w_q) < WEAK_THR);

endmodule
`default_nettype wire

// File: rtl/rx_qpsk_demapper.sv
`default_nettype none
// ============================================================================
// Module      : rx_qpsk_demapper
// Description : Slices QPSK symbols, packs four per byte MSB-first, flags weak bytes.
// Revision    : 1.0
// ============================================================================
module rx_qpsk_demapper #(
    parameter int                  SAMPLE_W = 12,
    parameter logic [SAMPLE_W-1:0] WEAK_THR = 12'd724,
    parameter int                  CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [2*SAMPLE_W-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    output logic                  out_last,
    output logic                  out_weak,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      weak_cnt
);
    import rx_pkg::*;

    logic             w_bit_i;
    logic             w_bit_q;
    logic             w_weak;
    logic             w_accept;
    logic             w_close;
    logic [7:0]       w_byte;

    logic [1:0]       sym_cnt_q,   sym_cnt_d;
    logic [7:0]       sr_q,        sr_d;
    logic             weak_acc_q,  weak_acc_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q,  out_data_d;
    logic             out_last_q,  out_last_d;
    logic             out_weak_q,  out_weak_d;
    logic [CNT_W-1:0] weak_cnt_q,  weak_cnt_d;

    qpsk_slicer #(
        .SAMPLE_W (SAMPLE_W),
        .WEAK_THR (WEAK_THR)
    ) u_slicer (
        .iq_i    (in_data),
        .bit_i_o (w_bit_i),
        .bit_q_o (w_bit_q),
        .weak_o  (w_weak)
    );

    assign in_ready = ~out_valid_q | out_ready;
    assign w_accept = in_valid & in_ready;
    assign w_close  = (sym_cnt_q == 2'd3) | in_last;

    // Merge the current symbol into its slot; unfilled low slots stay zero
    always_comb begin
        w_byte = sr_q;
        case (sym_cnt_q)
            2'd0:    w_byte[7:6] = {w_bit_i, w_bit_q};
            2'd1:    w_byte[5:4] = {w_bit_i, w_bit_q};
            2'd2:    w_byte[3:2] = {w_bit_i, w_bit_q};
            default: w_byte[1:0] = {w_bit_i, w_bit_q};
        endcase
    end

    always_comb begin
        sym_cnt_d   = sym_cnt_q;
        sr_d        = sr_q;
        weak_acc_d  = weak_acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_weak_d  = out_weak_q;
        weak_cnt_d  = weak_cnt_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // A load can only happen when the register is empty or draining
        if (w_accept) begin
            if (w_close) begin
                out_valid_d = 1'b1;
                out_data_d  = w_byte;
                out_last_d  = in_last;
                out_weak_d  = weak_acc_q | w_weak;
                sr_d        = 8'h00;
                sym_cnt_d   = 2'd0;
                weak_acc_d  = 1'b0;
            end else begin
                sr_d        = w_byte;
                sym_cnt_d   = sym_cnt_q + 2'd1;
                weak_acc_d  = weak_acc_q | w_weak;
            end
            if (w_weak && (weak_cnt_q != {CNT_W{1'b1}})) begin
                weak_cnt_d = weak_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sym_cnt_q   <= 2'd0;
            sr_q        <= 8'h00;
            weak_acc_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
            out_weak_q  <= 1'b0;
            weak_cnt_q  <= '0;
        end else begin
            sym_cnt_q   <= sym_cnt_d;
            sr_q        <= sr_d;
            weak_acc_q  <= weak_acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_weak_q  <= out_weak_d;
            weak_cnt_q  <= weak_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_weak  = out_weak_q;
    assign weak_cnt  = weak_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_qpsk_demapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_qpsk_demapper
// Description : Scoreboard bench for rx_qpsk_demapper with directed symbol vectors.
// Revision    : 1.0
// ============================================================================
module tb_rx_qpsk_demapper;

    localparam int C_SW = 12;
    localparam logic [C_SW-1:0] C_P = 12'h5A7;
    localparam logic [C_SW-1:0] C_N = 12'hA59;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       w;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [2*C_SW-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic              out_valid;
    logic [7:0]        out_data;
    logic              out_last;
    logic              out_weak;
    logic              out_ready = 1'b1;
    logic [15:0]       weak_cnt;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    rx_qpsk_demapper #(
        .SAMPLE_W (C_SW),
        .WEAK_THR (12'd724),
        .CNT_W    (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_weak  (out_weak),
        .out_ready (out_ready),
        .weak_cnt  (weak_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Drive one symbol at a negedge; returns at the negedge after it was accepted
    task automatic send(input logic [C_SW-1:0] i, input logic [C_SW-1:0] q, input logic last);
        int tries;
        in_valid = 1'b1;
        in_data  = {i, q};
        in_last  = last;
        #1;
        tries = 0;
        while (!in_ready && tries < 200) begin
            @(negedge clk);
            #1;
            tries++;
        end
        if (!in_ready) begin
            chk("send_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic l, input logic w);
        exp_t e;
        e.d = d;
        e.l = l;
        e.w = w;
        exp_q.push_back(e);
    endtask

    // Reference TX mapper: bit 1 -> +1.0, bit 0 -> -1.0
    task automatic send_byte(input logic [7:0] b, input logic last);
        for (int k = 0; k < 4; k++) begin
            send(b[7-2*k] ? C_P : C_N, b[6-2*k] ? C_P : C_N, last && (k == 3));
        end
    endtask

    // Monitor: a transfer happens at the posedge following a cycle with valid & ready
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", {24'd0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", {24'd0, out_data}, {24'd0, e.d});
                    chk("out_last", {31'd0, out_last}, {31'd0, e.l});
                    chk("out_weak", {31'd0, out_weak}, {31'd0, e.w});
                end
            end
        end
    end

    initial begin
        logic [7:0] bytes [5];
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'hA5; bytes[3] = 8'h3C; bytes[4] = 8'h81;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  {24'd0, out_data},  32'd0);
        chk("rst_out_last",  {31'd0, out_last},  32'd0);
        chk("rst_out_weak",  {31'd0, out_weak},  32'd0);
        chk("rst_weak_cnt",  {16'd0, weak_cnt},  32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        @(negedge clk);

        // Basic packing: 10 01 11 00
        push(8'h9C, 1'b0, 1'b0);
        send(C_P, C_N, 1'b0);
        send(C_N, C_P, 1'b0);
        send(C_P, C_P, 1'b0);
        send(C_N, C_N, 1'b0);
        idle();
        #1;
        chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_out_data",  {24'd0, out_data},  32'h9C);
        @(negedge clk);

        // Ideal-amplitude round trip; last byte closes a frame on symbol 3
        for (int n = 0; n < 5; n++) begin
            push(bytes[n], n == 4, 1'b0);
            send_byte(bytes[n], n == 4);
        end
        idle();
        @(negedge clk);
        chk("ideal_weak_cnt", {16'd0, weak_cnt}, 32'd0);

        // Partial flush: 11 01 -> D0; stray in_last without valid is ignored
        push(8'hD0, 1'b1, 1'b0);
        send(C_P, C_P, 1'b0);
        send(C_N, C_P, 1'b1);
        idle();
        in_last = 1'b1;
        repeat (2) @(negedge clk);
        in_last = 1'b0;
        push(8'h7F, 1'b0, 1'b0);
        send(C_N, C_P, 1'b0);
        send(C_P, C_P, 1'b0);
        send(C_P, C_P, 1'b0);
        send(C_P, C_P, 1'b0);
        idle();
        @(negedge clk);

        // Weak symbols: 0x100 -> 1, 0xF00 -> 0; byte 11 00 11 00
        push(8'hCC, 1'b0, 1'b1);
        send(12'h100, C_P, 1'b0);
        send(12'hF00, C_N, 1'b0);
        send(C_P, C_P, 1'b0);
        send(C_N, C_N, 1'b0);
        idle();
        chk("weak_cnt_2", {16'd0, weak_cnt}, 32'd2);

        // Threshold and saturation edges: -2048, +724, -724 strong; 723, -723 weak
        push(8'h5C, 1'b0, 1'b1);
        send(12'h800, 12'h2D4, 1'b0);
        send(12'hD2C, C_P, 1'b0);
        send(12'h2D3, C_P, 1'b0);
        send(12'hD2D, C_N, 1'b0);
        idle();
        chk("weak_cnt_4", {16'd0, weak_cnt}, 32'd4);

        // Zero decides 1 (and is weak); single-symbol frame
        push(8'h80, 1'b1, 1'b1);
        send(12'h000, C_N, 1'b1);
        idle();
        chk("weak_cnt_5", {16'd0, weak_cnt}, 32'd5);
        @(negedge clk);

        // Backpressure: one byte pending, eight more symbols offered
        out_ready = 1'b0;
        push(8'h36, 1'b0, 1'b0);
        send_byte(8'h36, 1'b0);
        push(8'hE4, 1'b0, 1'b0);
        push(8'h1B, 1'b0, 1'b0);
        fork
            begin
                send_byte(8'hE4, 1'b0);
                send_byte(8'h1B, 1'b0);
                idle();
            end
            begin
                repeat (4) begin
                    @(negedge clk);
                    #1;
                    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
                    chk("bp_out_data", {24'd0, out_data}, 32'h36);
                end
                @(negedge clk);
                out_ready = 1'b1;
                #1;
                chk("bp_drain_in_ready", {31'd0, in_ready}, 32'd1);
                @(posedge clk);
                @(negedge clk);
                out_ready = 1'b0;
                #1;
                chk("bp_drained_valid", {31'd0, out_valid}, 32'd0);
                repeat (8) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        repeat (3) @(negedge clk);

        // Reset mid-byte discards the partial and clears the counter
        send(C_N, C_N, 1'b0);
        send(C_N, C_N, 1'b0);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst2_weak_cnt",  {16'd0, weak_cnt},  32'd0);
        chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        push(8'hFF, 1'b0, 1'b0);
        send(C_P, C_P, 1'b0);
        send(C_P, C_P, 1'b0);
        send(C_P, C_P, 1'b0);
        send(C_P, C_P, 1'b0);
        idle();
        chk("post_rst_weak_cnt", {16'd0, weak_cnt}, 32'd0);

        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
